// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: SAR controller state encoding and
// helpers that size the probe index and comparator wait counter.
package arith_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PROBE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } sarState_t;

   // Width needed to index WIDTH bit positions (at least one bit).
   function automatic int unsigned idxWidth(input int unsigned width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

   // Width needed to count CMP_LATENCY wait cycles (at least one bit).
   function automatic int unsigned waitWidth(input int unsigned latency);
      return (latency > 1) ? $clog2(latency) : 1;
   endfunction

endpackage

// File: rtl/sar_probe_shifter.sv
// Probe bit tracker for the SAR search: holds the current bit index and its
// one-hot trial mask, walking from the MSB down to bit 0.
module sar_probe_shifter
   import arith_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   output logic [WIDTH-1:0] bitMask,
   output logic             last
);

   localparam int unsigned IDX_W = idxWidth(WIDTH);

   logic [IDX_W-1:0] idx;

   // Reset and load both restart the walk at the MSB.
   always_ff @(posedge clock) begin
      if (reset || load) begin
         idx     <= IDX_W'(WIDTH - 1);
         bitMask <= WIDTH'(1) << (WIDTH - 1);
      end else if (shift && (idx != '0)) begin
         idx     <= idx - IDX_W'(1);
         bitMask <= bitMask >> 1;
      end
   end

   assign last = (idx == '0);

endmodule

// File: rtl/sar_search_engine.sv
// Successive-approximation search controller driving comparator input B.
// Optional early exit on equality is enabled by defining SAR_EARLY_EXIT_EN.
module sar_search_engine
   import arith_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned CMP_LATENCY = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   output logic             ready,
   output logic [WIDTH-1:0] trialValue,
   input  logic             cmpEqual,
   input  logic             cmpGreater,
   input  logic             cmpLess,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             error
);

   localparam int unsigned WAIT_W = waitWidth(CMP_LATENCY);

   sarState_t        state;
   sarState_t        nextState;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] accNext;
   logic [WIDTH-1:0] bitMask;
   logic [WIDTH-1:0] probeValue;
   logic [WAIT_W-1:0] waitCnt;
   logic             last;
   logic             accept;
   logic             sampleNow;
   logic             flagsValid;
   logic             hitEqual;
   logic             finish;

   sar_probe_shifter #(.WIDTH(WIDTH)) probeShifter (
      .clock   (clock),
      .reset   (reset),
      .load    (accept),
      .shift   (sampleNow && !finish),
      .bitMask (bitMask),
      .last    (last)
   );

   // Flags are sampled in the final cycle the trial has been held.
   assign accept     = (state == S_IDLE) && start;
   assign sampleNow  = ((state == S_PROBE) && (CMP_LATENCY == 0)) ||
                       ((state == S_WAIT) && (waitCnt == WAIT_W'(CMP_LATENCY - 1)));
   assign flagsValid = ( cmpEqual & ~cmpGreater & ~cmpLess) |
                       (~cmpEqual &  cmpGreater & ~cmpLess) |
                       (~cmpEqual & ~cmpGreater &  cmpLess);
   assign probeValue = acc | bitMask;
   assign accNext    = (cmpGreater | cmpEqual) ? probeValue : acc;

`ifdef SAR_EARLY_EXIT_EN
   assign hitEqual = cmpEqual;
`else
   assign hitEqual = 1'b0;
`endif

   assign finish = sampleNow && (!flagsValid || hitEqual || last);

   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         S_IDLE:  if (start) nextState = S_PROBE;
         S_PROBE: begin
            if (!sampleNow)  nextState = S_WAIT;
            else if (finish) nextState = S_DONE;
            else             nextState = S_PROBE;
         end
         S_WAIT:  if (sampleNow) nextState = finish ? S_DONE : S_PROBE;
         S_DONE:  nextState = S_IDLE;
         default: nextState = S_IDLE;
      endcase
   end

   always_comb begin
      ready      = (state == S_IDLE);
      done       = (state == S_DONE);
      trialValue = '0;
      if ((state == S_PROBE) || (state == S_WAIT)) trialValue = probeValue;
   end

   // Accumulator, wait counter and result/error capture.
   always_ff @(posedge clock) begin
      if (reset) begin
         acc     <= '0;
         result  <= '0;
         error   <= 1'b0;
         waitCnt <= '0;
      end else begin
         if ((state == S_WAIT) && !sampleNow) waitCnt <= waitCnt + WAIT_W'(1);
         else                                 waitCnt <= '0;

         if (accept) begin
            acc   <= '0;
            error <= 1'b0;
         end else if (sampleNow) begin
            if (!flagsValid) begin
               error  <= 1'b1;
               result <= acc;
            end else begin
               acc <= accNext;
               if (finish) result <= accNext;
            end
         end
      end
   end

endmodule
